// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM states, default geometry and address helpers for the memory port arbiter
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

   localparam int BLOCK_BYTES = 16;
   localparam int OFFSET_BITS = $clog2(BLOCK_BYTES);
   localparam int INDEX_BITS  = 10;
   localparam int ID_W        = 1;

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Upper address bits beyond the array depth are dropped, so addresses alias.
   function automatic logic [63:0] block_index(input logic [63:0] addr, input int offset_bits, input int depth);
      return (addr >> offset_bits) & 64'(depth - 1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first eligible requester after i_last
module rr_arbiter
   import mem_arb_pkg::*;
#(
   parameter int N = 2
) (
   input  logic [N-1:0]                i_req,
   input  logic [N-1:0]                i_elig,
   input  logic [clog2_min1(N)-1:0]    i_last,
   output logic [N-1:0]                o_gnt,
   output logic                        o_valid
);

   logic [N-1:0] w_m;

   assign w_m     = i_req & i_elig;
   assign o_valid = |w_m;

   // Scanning from the farthest slot down lets the nearest candidate after i_last win.
   always_comb begin
      o_gnt = '0;
      for (int o = N; o >= 1; o--)
         if (1'(w_m >> ((int'(i_last) + o) % N))) o_gnt = N'(1) << ((int'(i_last) + o) % N);
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin multi-port block memory with fixed access latency
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_PORTS        = 2,
   parameter int ADDR_W           = 32,
   parameter int WORD_W           = 32,
   parameter int BLOCK_WORDS      = 4,
   parameter int MEM_DEPTH_BLOCKS = 1024,
   parameter int LATENCY          = 4
) (
   input  logic                                     clock,
   input  logic                                     reset,
   input  logic [NUM_PORTS-1:0]                     req,
   input  logic [NUM_PORTS-1:0]                     we,
   input  logic [NUM_PORTS*ADDR_W-1:0]              addr,
   input  logic [NUM_PORTS*BLOCK_WORDS*WORD_W-1:0]  wdata,
   output logic [BLOCK_WORDS*WORD_W-1:0]            rdata,
   output logic [NUM_PORTS-1:0]                     ack,
   output logic                                     busy,
   output logic [clog2_min1(NUM_PORTS)-1:0]         grant_id
);

   localparam int BLK_W    = BLOCK_WORDS * WORD_W;
   localparam int ID_BITS  = clog2_min1(NUM_PORTS);
   localparam int OFF_BITS = $clog2(BLK_W / 8);
   localparam int IDX_BITS = clog2_min1(MEM_DEPTH_BLOCKS);
   localparam int CNT_W    = clog2_min1(LATENCY);

   state_t               r_state, w_next;
   logic [ID_BITS-1:0]   r_id, r_last, r_grant_id, w_gid;
   logic                 r_we, r_bo;
   logic [IDX_BITS-1:0]  r_idx, w_idx;
   logic [BLK_W-1:0]     r_wdata, r_rdata;
   logic [CNT_W-1:0]     r_cnt;
   logic [BLK_W-1:0]     r_mem [MEM_DEPTH_BLOCKS];
   logic [ADDR_W-1:0]    w_addr [NUM_PORTS];
   logic [BLK_W-1:0]     w_wdata [NUM_PORTS];
   logic [NUM_PORTS-1:0] w_gnt, w_elig;
   logic                 w_valid, w_grant, w_commit;

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_p
      assign w_addr[i]  = addr[i*ADDR_W +: ADDR_W];
      assign w_wdata[i] = wdata[i*BLK_W +: BLK_W];
   end

   // The port served last is masked for the single idle cycle following its ack.
   assign w_elig = r_bo ? ~(NUM_PORTS'(1) << r_id) : '1;

   rr_arbiter #(.N(NUM_PORTS)) u_rr (
      .i_req   (req),
      .i_elig  (w_elig),
      .i_last  (r_last),
      .o_gnt   (w_gnt),
      .o_valid (w_valid)
   );

   always_comb begin
      w_gid = '0;
      for (int i = 0; i < NUM_PORTS; i++)
         if (w_gnt[i]) w_gid = ID_BITS'(i);
   end

   assign w_idx = IDX_BITS'(block_index(64'(w_addr[w_gid]), OFF_BITS, MEM_DEPTH_BLOCKS));

   always_comb begin
      w_grant  = (r_state == IDLE) && w_valid;
      w_commit = (r_state == ACCESS) && (r_cnt == '0);
      w_next   = w_grant ? ACCESS : w_commit ? RESPOND : (r_state == RESPOND) ? IDLE : r_state;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= IDLE;
         r_last     <= ID_BITS'(NUM_PORTS - 1);
         r_grant_id <= '0;
         r_rdata    <= '0;
         r_bo       <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_state <= w_next;
         r_bo    <= (r_state == RESPOND);
         if (w_grant) begin
            r_last     <= w_gid;
            r_grant_id <= w_gid;
            r_cnt      <= CNT_W'(LATENCY - 1);
         end else if (r_state == ACCESS) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_commit && !r_we) r_rdata <= r_mem[r_idx];
      end
   end

   // Transaction fields and the array are not reset; a commit coinciding with reset is dropped.
   always_ff @(posedge clock) begin
      if (w_grant) begin
         r_id    <= w_gid;
         r_we    <= we[w_gid];
         r_idx   <= w_idx;
         r_wdata <= w_wdata[w_gid];
      end
      if (w_commit && r_we && !reset) r_mem[r_idx] <= r_wdata;
   end

   assign ack      = (r_state == RESPOND) ? NUM_PORTS'(1) << r_id : '0;
   assign busy     = (r_state != IDLE);
   assign rdata    = r_rdata;
   assign grant_id = r_grant_id;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized and directed transactions against a transaction-level reference model
module tb_mem_port_arbiter;

   localparam int LA = 4;
   localparam int LB = 1;

   typedef struct {
      logic         we;
      logic [31:0]  ad;
      logic [127:0] wd;
   } txn_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         a_rst, b_rst;
   logic [2:0]   req_v, we_v;
   logic [31:0]  ad_v [3];
   logic [127:0] wd_v [3];
   int           cur = 0, np = 2, lat = LA, depth = 1024;

   logic [1:0]   a_ack;
   logic         a_busy;
   logic [0:0]   a_gid;
   logic [127:0] a_rd;
   logic [2:0]   b_ack;
   logic         b_busy;
   logic [1:0]   b_gid;
   logic [127:0] b_rd;

   mem_port_arbiter #(.NUM_PORTS(2), .LATENCY(LA)) u_a (
      .clock    (clk),
      .reset    (a_rst),
      .req      (cur == 0 ? req_v[1:0] : 2'b00),
      .we       (we_v[1:0]),
      .addr     ({ad_v[1], ad_v[0]}),
      .wdata    ({wd_v[1], wd_v[0]}),
      .rdata    (a_rd),
      .ack      (a_ack),
      .busy     (a_busy),
      .grant_id (a_gid)
   );

   mem_port_arbiter #(.NUM_PORTS(3), .LATENCY(LB), .MEM_DEPTH_BLOCKS(16)) u_b (
      .clock    (clk),
      .reset    (b_rst),
      .req      (cur == 1 ? req_v : 3'b000),
      .we       (we_v),
      .addr     ({ad_v[2], ad_v[1], ad_v[0]}),
      .wdata    ({wd_v[2], wd_v[1], wd_v[0]}),
      .rdata    (b_rd),
      .ack      (b_ack),
      .busy     (b_busy),
      .grant_id (b_gid)
   );

   int n_pass = 0, n_chk = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   int           cyc = 0, start = 0, last = 1, prev_cyc = -10, prev_port = -1, gmax = 0;
   logic [2:0]   rh [16384];
   logic         bh [16384];
   bit           chg [3];
   int           gap [3];
   txn_t         q [3][$];
   logic [127:0] mem [int];
   int           served [$];
   int           ack_at [$];
   logic [127:0] last_rd;
   logic [2:0]   ack_s;
   logic         busy_s;
   logic [1:0]   gid_s;
   logic [127:0] rd_s;

   task automatic model_reset();
      last = np - 1;
      prev_port = -1;
      prev_cyc = -10;
      start = cyc;
      served.delete();
      ack_at.delete();
   endtask

   // Expected grant: first cycle since the last completion with an eligible request,
   // picked round-robin after the last served port; completion lat+1 cycles later.
   task automatic on_ack(input int c);
      int p = -1, eg = -1, ep = -1, idx;
      bit ok = 1'b1;
      logic [2:0] el;
      check("ack_onehot", $countones(ack_s), 1);
      for (int i = np - 1; i >= 0; i--) if (ack_s[i]) p = i;
      for (int k = start; k < c && eg < 0; k++) begin
         el = rh[k];
         if (k == prev_cyc + 1 && prev_port >= 0) el[prev_port] = 1'b0;
         if (el != 0) begin
            eg = k;
            for (int o = 1; o <= np; o++) if (ep < 0 && el[(last + o) % np]) ep = (last + o) % np;
         end
      end
      check("ack_port", p, ep);
      check("ack_cycle", c, eg + lat + 1);
      if (eg < 0) ok = 1'b0;
      else for (int k = start; k <= c; k++) if (bh[k] !== (k > eg)) ok = 1'b0;
      check("busy_window", ok, 1);
      check("grant_id", gid_s, p);
      idx = int'((ad_v[p] >> 4) % depth);
      if (we_v[p]) mem[idx] = wd_v[p];
      else begin
         last_rd = rd_s;
         if (mem.exists(idx)) check("rdata", rd_s, mem[idx]);
      end
      last = p;
      prev_cyc = c;
      prev_port = p;
      start = c + 1;
      chg[p] = 1'b1;
      served.push_back(p);
      ack_at.push_back(c);
   endtask

   task automatic step();
      rh[cyc] = req_v;
      @(posedge clk);
      #1;
      cyc++;
      ack_s  = cur == 0 ? {1'b0, a_ack} : b_ack;
      busy_s = cur == 0 ? a_busy : b_busy;
      gid_s  = cur == 0 ? {1'b0, a_gid} : b_gid;
      rd_s   = cur == 0 ? a_rd : b_rd;
      bh[cyc] = busy_s;
      for (int i = 0; i < np; i++) begin
         if (chg[i]) begin
            chg[i] = 1'b0;
            void'(q[i].pop_front());
            req_v[i] = 1'b0;
            gap[i] = $urandom_range(gmax, 0);
         end
         if (!req_v[i] && q[i].size() > 0) begin
            if (gap[i] == 0) begin
               req_v[i] = 1'b1;
               we_v[i]  = q[i][0].we;
               ad_v[i]  = q[i][0].ad;
               wd_v[i]  = q[i][0].wd;
            end else gap[i]--;
         end
      end
      if (ack_s != 0) on_ack(cyc);
   endtask

   task automatic run(input int budget);
      int n = 0;
      while (n < budget && (q[0].size() + q[1].size() + q[2].size() > 0 || req_v != 0 || busy_s)) begin
         step();
         n++;
      end
      check("drain", n < budget, 1);
   endtask

   task automatic do_reset();
      for (int i = 0; i < 3; i++) begin
         q[i].delete();
         chg[i] = 1'b0;
         gap[i] = 0;
      end
      req_v = '0;
      if (cur == 0) a_rst = 1'b1; else b_rst = 1'b1;
      step();
      step();
      a_rst = 1'b0;
      b_rst = 1'b0;
      model_reset();
   endtask

   task automatic push(input int p, input logic w, input logic [31:0] a, input logic [127:0] d);
      txn_t t;
      t.we = w;
      t.ad = a;
      t.wd = d;
      q[p].push_back(t);
   endtask

   task automatic rnd_txns(input int n);
      logic [31:0] a;
      for (int i = 0; i < np; i++)
         for (int j = 0; j < n; j++) begin
            a = ($urandom & ~((depth - 1) << 4)) | ($urandom_range(7, 0) << 4);
            push(i, 1'($urandom), a, {$urandom, $urandom, $urandom, $urandom});
         end
   endtask

   initial begin
      int s, n, cnt;
      logic [127:0] blk;
      a_rst = 1'b1;
      b_rst = 1'b1;
      req_v = '0;
      we_v = '0;
      for (int i = 0; i < 3; i++) begin
         ad_v[i] = '0;
         wd_v[i] = '0;
      end
      do_reset();
      check("rst_ack", ack_s, 0);
      check("rst_busy", busy_s, 0);
      check("rst_rdata", rd_s, 0);
      check("rst_grant_id", gid_s, 0);
      blk = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
      s = cyc;
      push(1, 1'b1, 32'h40, blk);
      run(100);
      check("wr_ack_cycle", ack_at[0], s + 6);
      s = cyc;
      push(0, 1'b0, 32'h40, '0);
      run(100);
      check("rd_ack_cycle", ack_at[1], s + 6);
      check("rd_block", last_rd, blk);
      do_reset();
      push(0, 1'b0, 32'h40, '0);
      push(1, 1'b0, 32'h40, '0);
      run(100);
      check("simul_first", served[0], 0);
      check("simul_second", served[1], 1);
      push(0, 1'b1, 32'h4000, 128'hDEADBEEF);
      run(100);
      push(1, 1'b0, 32'h0, '0);
      run(100);
      check("wrap_alias", last_rd[31:0], 32'hDEADBEEF);
      push(0, 1'b1, 32'h80, {4{32'hA5A5A5A5}});
      run(100);
      push(0, 1'b1, 32'h80, {4{32'h5A5A5A5A}});
      n = 0;
      while (!busy_s && n < 20) begin
         step();
         n++;
      end
      check("midrst_granted", busy_s, 1);
      step();
      q[0].delete();
      req_v = '0;
      a_rst = 1'b1;
      step();
      check("midrst_ack", ack_s, 0);
      check("midrst_busy", busy_s, 0);
      a_rst = 1'b0;
      model_reset();
      push(1, 1'b0, 32'h80, '0);
      run(100);
      check("midrst_old_data", last_rd, {4{32'hA5A5A5A5}});
      gmax = 3;
      rnd_txns(40);
      run(3000);
      gmax = 0;
      cur = 1;
      np = 3;
      lat = LB;
      depth = 16;
      mem.delete();
      do_reset();
      s = cyc;
      push(0, 1'b0, 32'h10, '0);
      push(0, 1'b0, 32'h20, '0);
      run(50);
      check("l1_ack_cycle", ack_at[0], s + 3);
      cnt = 0;
      for (int k = s; k <= ack_at[0]; k++) cnt += int'(bh[k]);
      check("l1_busy_cycles", cnt, 2);
      check("l1_blackout", ack_at[1] - ack_at[0], 4);
      do_reset();
      for (int i = 0; i < 3; i++) begin
         push(i, 1'b0, 32'h30, '0);
         push(i, 1'b0, 32'h30, '0);
      end
      run(100);
      check("rr_count", served.size(), 6);
      for (int k = 0; k < served.size() && k < 6; k++) check("rr_seq", served[k], k % 3);
      gmax = 2;
      rnd_txns(40);
      run(3000);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
